axi_lite_iic_cmd_master: RTL

//  Upstream AXI4-Lite master that feeds axi_lite_iic_master. Accepts one register command at a

---
 rtl/axi_lite_iic_cmd_master.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_iic_cmd_master.sv
// axi_lite_iic_cmd_master: accepts one register command at a time and runs it as a
// single AXI4-Lite write (AW+W then B) or read (AR then R), returning read data,
// bresp error and timeout status on a valid/ready response port. All outputs are flops.
module axi_lite_iic_cmd_master #(
  parameter int C_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // AXI4-Lite master
  output logic [31:0] axi_lite_awaddr,
  output logic        axi_lite_awvalid,
  input  logic        axi_lite_awready,
  output logic [31:0] axi_lite_wdata,
  output logic        axi_lite_wvalid,
  input  logic        axi_lite_wready,
  input  logic [1:0]  axi_lite_bresp,
  input  logic        axi_lite_bvalid,
  output logic        axi_lite_bready,
  output logic [31:0] axi_lite_araddr,
  output logic        axi_lite_arvalid,
  input  logic        axi_lite_arready,
  input  logic [31:0] axi_lite_rdata,
  input  logic        axi_lite_rvalid,
  output logic        axi_lite_rready
);

  // Counter only needs to reach C_TIMEOUT-1; a zero timeout disables expiry entirely.
  localparam int              CNT_W    = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (C_TIMEOUT > 0) ? CNT_W'(C_TIMEOUT - 1) : '0;
  localparam logic            TO_EN    = (C_TIMEOUT > 0);

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              aw_done, aw_done_nxt;
  logic              w_done, w_done_nxt;
  logic              expired;
  logic              abort;
  logic              aw_hs, w_hs;

  logic        cmd_ready_nxt;
  logic        rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [31:0] rsp_rdata_nxt;
  logic [31:0] awaddr_nxt, wdata_nxt, araddr_nxt;
  logic        awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;

  assign expired = TO_EN && (cnt == CNT_LAST);
  assign aw_hs   = axi_lite_awvalid & axi_lite_awready;
  assign w_hs    = axi_lite_wvalid & axi_lite_wready;

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    // NOTE: every *_nxt gets a default first so no path through the case infers a latch.
    state_nxt       = state;
    aw_done_nxt     = aw_done;
    w_done_nxt      = w_done;
    abort           = 1'b0;
    cmd_ready_nxt   = cmd_ready;
    rsp_valid_nxt   = rsp_valid;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    rsp_rdata_nxt   = rsp_rdata;
    awaddr_nxt      = axi_lite_awaddr;
    wdata_nxt       = axi_lite_wdata;
    araddr_nxt      = axi_lite_araddr;
    awvalid_nxt     = axi_lite_awvalid;
    wvalid_nxt      = axi_lite_wvalid;
    bready_nxt      = axi_lite_bready;
    arvalid_nxt     = axi_lite_arvalid;
    rready_nxt      = axi_lite_rready;

    unique case (state)
      IDLE: begin
        cmd_ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_nxt = 1'b0;
          awaddr_nxt    = cmd_addr;
          araddr_nxt    = cmd_addr;
          wdata_nxt     = cmd_wdata;
          if (cmd_write) begin
            state_nxt   = WR_AW_W;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
          end else begin
            state_nxt   = RD_AR;
            arvalid_nxt = 1'b1;
          end
        end
      end

      WR_AW_W: begin
        if (aw_hs) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (w_hs) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt  = WR_B;
          bready_nxt = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end

      WR_B: begin
        if (axi_lite_bvalid && axi_lite_bready) begin
          state_nxt       = RESP;
          bready_nxt      = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = (axi_lite_bresp != 2'b00);
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = '0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end

      RD_AR: begin
        if (axi_lite_arvalid && axi_lite_arready) begin
          state_nxt   = RD_R;
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end

      RD_R: begin
        if (axi_lite_rvalid && axi_lite_rready) begin
          state_nxt       = RESP;
          rready_nxt      = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b0;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = axi_lite_rdata;
        end else if (expired) begin
          abort = 1'b1;
        end
      end

      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Timeout recovery: drop every AXI valid/ready even mid-handshake and report.
    if (abort) begin
      state_nxt       = RESP;
      awvalid_nxt     = 1'b0;
      wvalid_nxt      = 1'b0;
      bready_nxt      = 1'b0;
      arvalid_nxt     = 1'b0;
      rready_nxt      = 1'b0;
      rsp_valid_nxt   = 1'b1;
      rsp_timeout_nxt = 1'b1;
      rsp_err_nxt     = 1'b0;
      rsp_rdata_nxt   = '0;
    end

    // Wait counter restarts on every state change and counts cycles spent in a state.
    cnt_nxt = (state_nxt != state) ? '0 : cnt + 1'b1;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values together.
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      aw_done          <= 1'b0;
      w_done           <= 1'b0;
      cmd_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_timeout      <= 1'b0;
      rsp_rdata        <= '0;
      axi_lite_awaddr  <= '0;
      axi_lite_wdata   <= '0;
      axi_lite_araddr  <= '0;
      axi_lite_awvalid <= 1'b0;
      axi_lite_wvalid  <= 1'b0;
      axi_lite_bready  <= 1'b0;
      axi_lite_arvalid <= 1'b0;
      axi_lite_rready  <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      aw_done          <= aw_done_nxt;
      w_done           <= w_done_nxt;
      cmd_ready        <= cmd_ready_nxt;
      rsp_valid        <= rsp_valid_nxt;
      rsp_err          <= rsp_err_nxt;
      rsp_timeout      <= rsp_timeout_nxt;
      rsp_rdata        <= rsp_rdata_nxt;
      axi_lite_awaddr  <= awaddr_nxt;
      axi_lite_wdata   <= wdata_nxt;
      axi_lite_araddr  <= araddr_nxt;
      axi_lite_awvalid <= awvalid_nxt;
      axi_lite_wvalid  <= wvalid_nxt;
      axi_lite_bready  <= bready_nxt;
      axi_lite_arvalid <= arvalid_nxt;
      axi_lite_rready  <= rready_nxt;
    end
  end

endmodule
